// File: rtl/mem_copy_if.sv
// picorv32-style native memory bus between the copy engine (master) and a memory responder (slave).
interface mem_copy_if;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_copy_master.sv
// Word-block copy engine on the picorv32 native bus: read src word, gap, write dst word, gap, repeat.
// Optional running checksum of read data when MEM_COPY_CHECKSUM_EN is defined.
module mem_copy_master #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [31:0]          src_addr_i,
  input  logic [31:0]          dst_addr_i,
  input  logic [LEN_WIDTH-1:0] len_words_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 aborted_o,
  output logic [LEN_WIDTH-1:0] words_done_o,
  output logic [31:0]          checksum_o,
  mem_copy_if.master           bus
);

  typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, WR_GAP} state_t;

  state_t               state_q, state_d;
  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [31:0]          data_q, data_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] words_q, words_d;
  logic                 done_q, done_d;
  logic                 aborted_q, aborted_d;
  logic                 valid;
  logic                 last;
  logic                 accept;

  // Bus outputs decode from registered state only, so they cannot glitch while mem_valid is high.
  assign valid          = (state_q == RD) || (state_q == WR);
  assign bus.mem_valid  = valid;
  assign bus.mem_instr  = 1'b0;
  assign bus.mem_addr   = (state_q == RD) ? src_q : ((state_q == WR) ? dst_q : 32'h0);
  assign bus.mem_wdata  = (state_q == WR) ? data_q : 32'h0;
  assign bus.mem_wstrb  = (state_q == WR) ? 4'b1111 : 4'b0000;

  assign last   = (words_q + LEN_WIDTH'(1)) == len_q;
  assign accept = (state_q == IDLE) && start_i && (len_words_i != '0);

  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign aborted_o    = aborted_q;
  assign words_done_o = words_q;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    data_d    = data_q;
    len_d     = len_q;
    words_d   = words_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_words_i != '0) begin
            src_d     = src_addr_i & ~32'h3;
            dst_d     = dst_addr_i & ~32'h3;
            len_d     = len_words_i;
            words_d   = '0;
            aborted_d = 1'b0;
            state_d   = RD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RD: begin
        if (bus.mem_ready) begin
          data_d  = bus.mem_rdata;
          state_d = RD_GAP;
        end
      end
      RD_GAP: state_d = WR;
      WR: begin
        // Abort is only honoured once the write completes, so an issued read always lands.
        if (bus.mem_ready) begin
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          words_d = words_q + LEN_WIDTH'(1);
          if (last || abort_i) begin
            done_d    = 1'b1;
            aborted_d = abort_i && !last;
            state_d   = IDLE;
          end else begin
            state_d = WR_GAP;
          end
        end
      end
      WR_GAP: begin
        if (abort_i) begin
          done_d    = 1'b1;
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      src_q     <= 32'h0;
      dst_q     <= 32'h0;
      data_q    <= 32'h0;
      len_q     <= '0;
      words_q   <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      data_q    <= data_d;
      len_q     <= len_d;
      words_q   <= words_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (accept) begin
      sum_d = 32'h0;
    end else if ((state_q == RD) && bus.mem_ready) begin
      sum_d = sum_q + bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sum_q <= 32'h0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum_o = sum_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign checksum_o    = 32'h0;
`endif

endmodule

// File: tb/tb_mem_copy_master.sv
// Directed + randomized bench for mem_copy_master against a word-level copy model and a sparse memory responder.
module tb_mem_copy_master;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] src_addr = 32'h0;
  logic [31:0] dst_addr = 32'h0;
  logic [15:0] len_words = 16'h0;
  logic        busy, done, aborted;
  logic [15:0] words_done;
  logic [31:0] checksum;

  int n_tests = 0;
  int n_fail  = 0;

  mem_copy_if bus ();

  mem_copy_master #(.LEN_WIDTH(16)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start_i      (start),
    .abort_i      (abort),
    .src_addr_i   (src_addr),
    .dst_addr_i   (dst_addr),
    .len_words_i  (len_words),
    .busy_o       (busy),
    .done_o       (done),
    .aborted_o    (aborted),
    .words_done_o (words_done),
    .checksum_o   (checksum),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Sparse word memory keyed by byte address >> 2, plus a log of every completed transfer.
  logic [31:0] mem [bit [31:0]];
  logic [31:0] tr_addr[$];
  logic [3:0]  tr_strb[$];
  logic [31:0] tr_data[$];

  int          max_wait = 0;
  int          wait_left = 0;
  bit          pv = 1'b0, pr = 1'b0;
  logic [31:0] pa = 32'h0, pd = 32'h0;
  logic [3:0]  ps = 4'h0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a >> 2) ? mem[a >> 2] : 32'h0;
  endfunction

  // Responder and protocol monitor: decisions at negedge, so ready is stable across the next posedge.
  always @(negedge clk) begin
    if (!resetn) begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0;
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (pv && pr) chk("gap_after_handshake", 32'(bus.mem_valid), 32'h0);
      if (pv && !pr && bus.mem_valid) begin
        chk("stable_addr", bus.mem_addr, pa);
        chk("stable_wdata", bus.mem_wdata, pd);
        chk("stable_wstrb", 32'(bus.mem_wstrb), 32'(ps));
      end
      if (bus.mem_valid) begin
        chk("addr_aligned", 32'(bus.mem_addr[1:0]), 32'h0);
        chk("instr_zero", 32'(bus.mem_instr), 32'h0);
        if (!pv) wait_left = $urandom_range(0, max_wait);
        if (wait_left == 0) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem_rd(bus.mem_addr);
        end else begin
          wait_left--;
          bus.mem_ready = 1'b0;
        end
      end else begin
        bus.mem_ready = 1'b0;
      end
      pv = bus.mem_valid;
      pr = bus.mem_ready;
      pa = bus.mem_addr;
      pd = bus.mem_wdata;
      ps = bus.mem_wstrb;
    end
  end

  always @(posedge clk) begin
    if (resetn && bus.mem_valid && bus.mem_ready) begin
      tr_addr.push_back(bus.mem_addr);
      tr_strb.push_back(bus.mem_wstrb);
      tr_data.push_back((bus.mem_wstrb == 4'hF) ? bus.mem_wdata : bus.mem_rdata);
      if (bus.mem_wstrb == 4'hF) mem[bus.mem_addr >> 2] = bus.mem_wdata;
    end
  end

  task automatic clear_trace();
    tr_addr.delete();
    tr_strb.delete();
    tr_data.delete();
  endtask

  task automatic fill(input logic [31:0] s, input int n);
    for (int i = 0; i < n; i++) mem[((s & ~32'h3) + 32'(4 * i)) >> 2] = $urandom;
  endtask

  // Model: a job of n words (or aw words when aborted at the read of word aw) is
  // read src+4i, write dst+4i with that value, for i in order; checksum is the sum of values read.
  task automatic run_job(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                         input int aw, input int mw, input bit poke, input string nm);
    logic [31:0] sa, da, exp_sum;
    logic [31:0] vals[$];
    int          nw, cyc;
    bit          seen;
    sa = s & ~32'h3;
    da = d & ~32'h3;
    nw = (aw != 0) ? aw : int'(n);
    max_wait = mw;
    exp_sum = 32'h0;
    for (int i = 0; i < int'(n); i++) vals.push_back(mem_rd(sa + 32'(4 * i)));
    for (int i = 0; i < nw; i++) exp_sum += vals[i];
    clear_trace();

    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; len_words = n;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_busy_at_start"}, 32'(busy), 32'h1);
    chk({nm, "_rd_valid_at_start"}, 32'(bus.mem_valid), 32'h1);
    chk({nm, "_rd_addr_at_start"}, bus.mem_addr, sa);

    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 3000) begin
      if (aw != 0 && bus.mem_valid && bus.mem_wstrb == 4'h0 && bus.mem_addr == sa + 32'(4 * (aw - 1)))
        abort = 1'b1;
      if (poke && cyc == 5) begin
        start = 1'b1; src_addr = 32'h5555_0000; dst_addr = 32'h6666_0000; len_words = 16'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, 32'(seen), 32'h1);
    if (mw == 0 && aw == 0) chk({nm, "_cycles_to_done"}, 32'(cyc), 32'(4 * int'(n) - 1));
    chk({nm, "_busy_at_done"}, 32'(busy), 32'h0);
    chk({nm, "_words_done"}, 32'(words_done), 32'(nw));
    chk({nm, "_aborted"}, 32'(aborted), (aw != 0) ? 32'h1 : 32'h0);
`ifdef MEM_COPY_CHECKSUM_EN
    chk({nm, "_checksum"}, checksum, exp_sum);
`else
    chk({nm, "_checksum"}, checksum, 32'h0);
`endif
    abort = 1'b0;
    @(negedge clk);
    chk({nm, "_done_one_cycle"}, 32'(done), 32'h0);
    repeat (3) @(negedge clk);
    chk({nm, "_idle_valid"}, 32'(bus.mem_valid), 32'h0);

    chk({nm, "_trace_len"}, 32'(tr_addr.size()), 32'(2 * nw));
    if (tr_addr.size() == 2 * nw) begin
      for (int i = 0; i < nw; i++) begin
        chk({nm, "_rd_addr"}, tr_addr[2 * i], sa + 32'(4 * i));
        chk({nm, "_rd_strb"}, 32'(tr_strb[2 * i]), 32'h0);
        chk({nm, "_rd_data"}, tr_data[2 * i], vals[i]);
        chk({nm, "_wr_addr"}, tr_addr[2 * i + 1], da + 32'(4 * i));
        chk({nm, "_wr_strb"}, 32'(tr_strb[2 * i + 1]), 32'hF);
        chk({nm, "_wr_data"}, tr_data[2 * i + 1], vals[i]);
        chk({nm, "_dst_mem"}, mem_rd(da + 32'(4 * i)), vals[i]);
      end
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, 32'(busy), 32'h0);
    chk({nm, "_done"}, 32'(done), 32'h0);
    chk({nm, "_aborted"}, 32'(aborted), 32'h0);
    chk({nm, "_words_done"}, 32'(words_done), 32'h0);
    chk({nm, "_checksum"}, checksum, 32'h0);
    chk({nm, "_valid"}, 32'(bus.mem_valid), 32'h0);
    chk({nm, "_addr"}, bus.mem_addr, 32'h0);
    chk({nm, "_wdata"}, bus.mem_wdata, 32'h0);
    chk({nm, "_wstrb"}, 32'(bus.mem_wstrb), 32'h0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    int lw, cnt;
    bit saw;
    logic [31:0] s;

    // Reset state
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    resetn = 1'b1;

    // Single word with the reference memory image
    mem[32'h100] = 32'hDEADBEEF;
    run_job(32'h400, 32'h800, 16'd1, 0, 0, 1'b0, "single");
    chk("single_dst_word", mem_rd(32'h800), 32'hDEADBEEF);

    // Zero-length job: done next cycle, no bus activity, never busy
    clear_trace();
    @(negedge clk);
    start = 1'b1; src_addr = 32'h900; dst_addr = 32'hA00; len_words = 16'd0;
    @(negedge clk);
    start = 1'b0;
    chk("len0_done", 32'(done), 32'h1);
    chk("len0_busy", 32'(busy), 32'h0);
    chk("len0_valid", 32'(bus.mem_valid), 32'h0);
    @(negedge clk);
    chk("len0_done_drop", 32'(done), 32'h0);
    chk("len0_no_bus", 32'(tr_addr.size()), 32'h0);

    // 4 words, random waits, with a start pulse while busy
    fill(32'h1000, 4);
    run_job(32'h1000, 32'h3000, 16'd4, 0, 5, 1'b1, "rand4");

    // Abort during read of word 3 of 8, then a clean job clears aborted
    fill(32'h4000, 8);
    run_job(32'h4000, 32'h5000, 16'd8, 3, 2, 1'b0, "abort");
    fill(32'h7000, 2);
    run_job(32'h7000, 32'h7800, 16'd2, 0, 0, 1'b0, "after_abort");

    // Source address wrap
    fill(32'hFFFF_FFF8, 3);
    run_job(32'hFFFF_FFF8, 32'h6000, 16'd3, 0, 1, 1'b0, "wrap");

    // Random jobs with unaligned address inputs
    for (int k = 0; k < 4; k++) begin
      s  = 32'h10000 + 32'(k * 32'h1000) + 32'($urandom_range(0, 3));
      lw = $urandom_range(1, 6);
      fill(s, lw);
      run_job(s, s + 32'h800, 16'(lw), 0, $urandom_range(0, 3), 1'b0, "rnd");
    end

    // Reset asserted while a write is on the bus
    fill(32'h2000, 4);
    max_wait = 3;
    @(negedge clk);
    start = 1'b1; src_addr = 32'h2000; dst_addr = 32'h2800; len_words = 16'd4;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    saw = 1'b0;
    while (!saw && cnt < 200) begin
      if (bus.mem_valid && bus.mem_wstrb == 4'hF) saw = 1'b1;
      else begin
        @(negedge clk);
        cnt++;
      end
    end
    chk("rst_mid_write_reached", 32'(saw), 32'h1);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("rst_mid_write");
    @(negedge clk);
    resetn = 1'b1;
    max_wait = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
